// File: rtl/uart_rx_pkt_ctrl.sv
// Packet sequencer behind the UART byte receiver: sync/len/payload/checksum,
// buffers the payload and streams it out only when the checksum is good.
module uart_rx_pkt_ctrl #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         MAX_LEN     = 8,
    parameter int         TIMEOUT_CYC = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       pkt_ok,
    output logic       chk_err,
    output logic       len_err,
    output logic       tmo_err,
    output logic       frm_err,
    output logic [7:0] drop_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0]    MAXL  = 8'(MAX_LEN);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, DRAIN} state_t;

    state_t        state, state_n;
    logic [3:0]    len, len_n, idx, idx_n, rd, rd_n;
    logic [7:0]    sum, sum_n, drop_n, odata_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          ovalid_n, olast_n, wr_en;
    logic          ok_n, chk_n, len_e_n, tmo_n, frm_n;
    logic [7:0]    mem [16];

    always_comb begin
        state_n  = state;
        len_n    = len;
        idx_n    = idx;
        rd_n     = rd;
        sum_n    = sum;
        drop_n   = drop_cnt;
        odata_n  = out_data;
        ovalid_n = out_valid;
        olast_n  = out_last;
        tcnt_n   = rx_valid ? '0 : tcnt + 1'b1;
        wr_en    = 1'b0;
        ok_n     = 1'b0;
        chk_n    = 1'b0;
        len_e_n  = 1'b0;
        tmo_n    = 1'b0;
        frm_n    = 1'b0;
        unique case (state)
            IDLE: begin
                tcnt_n = '0;
                if (rx_valid && rx_data == SYNC_BYTE)
                    state_n = LEN;
            end
            LEN, PAYLOAD, CHK: begin
                // framing error beats a coincident byte; a byte beats expiry
                if (rx_err) begin
                    frm_n   = 1'b1;
                    state_n = IDLE;
                end else if (rx_valid) begin
                    if (state == LEN) begin
                        if (rx_data == 8'd0 || rx_data > MAXL) begin
                            len_e_n = 1'b1;
                            state_n = IDLE;
                        end else begin
                            len_n   = rx_data[3:0];
                            sum_n   = rx_data;
                            idx_n   = '0;
                            state_n = PAYLOAD;
                        end
                    end else if (state == PAYLOAD) begin
                        wr_en = 1'b1;
                        sum_n = sum + rx_data;
                        idx_n = idx + 4'd1;
                        if (idx == len - 4'd1)
                            state_n = CHK;
                    end else if (8'(sum + rx_data) == 8'd0) begin
                        ok_n     = 1'b1;
                        rd_n     = '0;
                        ovalid_n = 1'b1;
                        odata_n  = mem[0];
                        olast_n  = (len == 4'd1);
                        state_n  = DRAIN;
                    end else begin
                        chk_n   = 1'b1;
                        state_n = IDLE;
                    end
                end else if (tcnt == TLAST) begin
                    tmo_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            DRAIN: begin
                tcnt_n = '0;
                if (rx_valid && drop_cnt != 8'hFF)
                    drop_n = drop_cnt + 8'd1;
                if (out_ready) begin
                    if (out_last) begin
                        ovalid_n = 1'b0;
                        olast_n  = 1'b0;
                        state_n  = IDLE;
                    end else begin
                        rd_n    = rd + 4'd1;
                        odata_n = mem[rd + 4'd1];
                        olast_n = (rd + 4'd1 == len - 4'd1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            len       <= '0;
            idx       <= '0;
            rd        <= '0;
            sum       <= '0;
            tcnt      <= '0;
            drop_cnt  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            pkt_ok    <= 1'b0;
            chk_err   <= 1'b0;
            len_err   <= 1'b0;
            tmo_err   <= 1'b0;
            frm_err   <= 1'b0;
        end else begin
            state     <= state_n;
            len       <= len_n;
            idx       <= idx_n;
            rd        <= rd_n;
            sum       <= sum_n;
            tcnt      <= tcnt_n;
            drop_cnt  <= drop_n;
            out_data  <= odata_n;
            out_valid <= ovalid_n;
            out_last  <= olast_n;
            pkt_ok    <= ok_n;
            chk_err   <= chk_n;
            len_err   <= len_e_n;
            tmo_err   <= tmo_n;
            frm_err   <= frm_n;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[idx] <= rx_data;
    end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Randomized self-checking bench for uart_rx_pkt_ctrl with a packet-level
// reference model and an output-stream scoreboard.
module tb_uart_rx_pkt_ctrl;

    localparam int MAXL = 8;
    localparam int TMO  = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_err = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data, drop_cnt;
    logic       out_valid, out_last;
    logic       pkt_ok, chk_err, len_err, tmo_err, frm_err;

    int n_cmp = 0;
    int n_err = 0;
    int c_ok = 0, c_chk = 0, c_len = 0, c_tmo = 0, c_frm = 0;
    logic [8:0] expq[$];
    bit rand_ready = 1'b0;

    uart_rx_pkt_ctrl dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last),
        .pkt_ok(pkt_ok), .chk_err(chk_err), .len_err(len_err),
        .tmo_err(tmo_err), .frm_err(frm_err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Pulse counters and output-stream scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            logic [8:0] e;
            c_ok  += int'(pkt_ok);
            c_chk += int'(chk_err);
            c_len += int'(len_err);
            c_tmo += int'(tmo_err);
            c_frm += int'(frm_err);
            n_cmp++;
            if ($countones({pkt_ok, chk_err, len_err, tmo_err, frm_err}) > 1) begin
                n_err++;
                $display("FAIL pulse_onehot: got %b want at most one",
                         {pkt_ok, chk_err, len_err, tmo_err, frm_err});
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_err++;
                    $display("FAIL stream_extra: got %h last=%b want nothing",
                             out_data, out_last);
                end else begin
                    e = expq.pop_front();
                    if ({out_last, out_data} !== e) begin
                        n_err++;
                        $display("FAIL stream_data: got last=%b %h want last=%b %h",
                                 out_last, out_data, e[8], e[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready)
                out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // Reference model: outcome of a framed packet from the protocol rules.
    // Returns 0 ok, 1 checksum error, 2 length error.
    function automatic int model(input int len, input logic [7:0] pl[$],
                                 input logic [7:0] chk);
        int s;
        if (len == 0 || len > MAXL)
            return 2;
        s = len + int'(chk);
        foreach (pl[i]) s += int'(pl[i]);
        return (s % 256 == 0) ? 0 : 1;
    endfunction

    task automatic expect_payload(input logic [7:0] pl[$]);
        foreach (pl[i]) expq.push_back({i == pl.size() - 1, pl[i]});
    endtask

    task automatic wait_drained(input string name);
        int k = 0;
        while ((expq.size() != 0 || out_valid) && k < 2000) begin
            tick();
            k++;
        end
        n_cmp++;
        if (k >= 2000) begin
            n_err++;
            $display("FAIL %s_drain_timeout: got %0d bytes left want 0",
                     name, expq.size());
        end
    endtask

    task automatic send_pkt3();
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({out_data, out_valid, out_last, pkt_ok, chk_err, len_err,
             tmo_err, frm_err, drop_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got nonzero outputs want all 0");
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] pl[$] = '{8'h11, 8'h22, 8'h33};
        int ok0 = c_ok, e0 = c_chk + c_len + c_tmo + c_frm;
        out_ready = 1'b1;
        expect_payload(pl);
        send_pkt3();
        send(8'h97);
        n_cmp++;
        if ({pkt_ok, out_valid, out_data, out_last} !== {1'b1, 1'b1, 8'h11, 1'b0}) begin
            n_err++;
            $display("FAIL basic_latency: got ok=%b v=%b d=%h want ok=1 v=1 d=11",
                     pkt_ok, out_valid, out_data);
        end
        tick(); tick(); tick();
        n_cmp++;
        if (out_valid !== 1'b0 || expq.size() != 0) begin
            n_err++;
            $display("FAIL basic_consecutive: got v=%b left=%0d want v=0 left=0",
                     out_valid, expq.size());
        end
        tick();
        n_cmp++;
        if (c_ok - ok0 != 1 || c_chk + c_len + c_tmo + c_frm != e0) begin
            n_err++;
            $display("FAIL basic_pulses: got ok=%0d want 1 with no errors", c_ok - ok0);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] pl[$] = '{8'h11, 8'h22, 8'h33};
        out_ready = 1'b0;
        expect_payload(pl);
        send_pkt3();
        send(8'h97);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if ({out_valid, out_data, out_last} !== {1'b1, 8'h11, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h l=%b want v=1 d=11 l=0",
                         i, out_valid, out_data, out_last);
            end
            tick();
        end
        out_ready = 1'b1;
        wait_drained("bp");
    endtask

    task automatic test_chk_err();
        logic [7:0] pl[$] = '{8'h55};
        send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
        n_cmp++;
        if ({chk_err, out_valid, pkt_ok} !== 3'b100) begin
            n_err++;
            $display("FAIL chk_err_pulse: got chk=%b v=%b ok=%b want 1 0 0",
                     chk_err, out_valid, pkt_ok);
        end
        expect_payload(pl);
        send(8'hA5); send(8'h01); send(8'h55); send(8'hAA);
        n_cmp++;
        if (pkt_ok !== 1'b1) begin
            n_err++;
            $display("FAIL chk_err_recover: got ok=%b want 1", pkt_ok);
        end
        wait_drained("chk");
    endtask

    task automatic test_len_err();
        logic [7:0] pl[$] = '{8'h55};
        logic [7:0] bad[2] = '{8'h00, 8'h09};
        foreach (bad[i]) begin
            send(8'hA5);
            send(bad[i]);
            n_cmp++;
            if (len_err !== 1'b1) begin
                n_err++;
                $display("FAIL len_err_%h: got %b want 1", bad[i], len_err);
            end
        end
        expect_payload(pl);
        send(8'hA5); send(8'h01); send(8'h55); send(8'hAA);
        n_cmp++;
        if (pkt_ok !== 1'b1 || out_data !== 8'h55) begin
            n_err++;
            $display("FAIL len_recover: got ok=%b d=%h want 1 55", pkt_ok, out_data);
        end
        wait_drained("len");
    endtask

    task automatic test_timeout();
        logic [7:0] pl[$] = '{8'h11, 8'h22, 8'h33};
        int t0, k;
        send(8'hA5); send(8'h03); send(8'h11);
        t0 = c_tmo;
        k = 0;
        while (tmo_err !== 1'b1 && k < TMO + 50) begin
            tick();
            k++;
        end
        n_cmp++;
        if (k != TMO) begin
            n_err++;
            $display("FAIL tmo_position: got %0d idle cycles want %0d", k, TMO);
        end
        tick(); tick();
        n_cmp++;
        if (c_tmo - t0 != 1) begin
            n_err++;
            $display("FAIL tmo_once: got %0d pulses want 1", c_tmo - t0);
        end
        // byte landing on the expiry cycle keeps the packet alive
        expect_payload(pl);
        send(8'hA5); send(8'h03); send(8'h11);
        for (int i = 0; i < TMO - 1; i++) tick();
        send(8'h22); send(8'h33); send(8'h97);
        n_cmp++;
        if (pkt_ok !== 1'b1 || tmo_err !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_boundary: got ok=%b tmo=%b want 1 0", pkt_ok, tmo_err);
        end
        wait_drained("tmo");
    endtask

    task automatic test_framing();
        int ok0 = c_ok;
        send(8'hA5); send(8'h03); send(8'h11);
        rx_err = 1'b1;
        send(8'h22);
        rx_err = 1'b0;
        n_cmp++;
        if (frm_err !== 1'b1) begin
            n_err++;
            $display("FAIL frm_pulse: got %b want 1", frm_err);
        end
        send(8'h33); send(8'h97);
        tick(); tick();
        n_cmp++;
        if (c_ok != ok0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL frm_no_pkt: got ok=%0d v=%b want 0 0", c_ok - ok0, out_valid);
        end
    endtask

    task automatic test_drop_and_async_reset();
        logic [7:0] pl[$] = '{8'h11, 8'h22, 8'h33};
        int f0;
        out_ready = 1'b0;
        expect_payload(pl);
        send_pkt3();
        send(8'h97);
        f0 = c_frm;
        send(8'h01); send(8'hA5);
        rx_err = 1'b1;
        send(8'h02);
        rx_err = 1'b0;
        tick();
        n_cmp++;
        if (drop_cnt !== 8'd3 || c_frm != f0) begin
            n_err++;
            $display("FAIL drop_cnt: got %0d frm=%0d want 3 frm=0", drop_cnt, c_frm - f0);
        end
        out_ready = 1'b1;
        wait_drained("drop");
        send(8'hA5); send(8'h03); send(8'h11);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_data, out_valid, out_last, pkt_ok, chk_err, len_err,
             tmo_err, frm_err, drop_cnt} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got drop=%0d d=%h want all 0", drop_cnt, out_data);
        end
        tick();
        rst = 1'b0;
        tick();
        expect_payload(pl);
        send_pkt3();
        send(8'h97);
        n_cmp++;
        if (pkt_ok !== 1'b1) begin
            n_err++;
            $display("FAIL reset_recover: got ok=%b want 1", pkt_ok);
        end
        wait_drained("rst");
    endtask

    task automatic test_random();
        rand_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            logic [7:0] pl[$];
            logic [7:0] b, chk;
            int len, s, exp_kind;
            int ok0 = c_ok, ck0 = c_chk, ln0 = c_len;
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                b = 8'($urandom);
                send(b == 8'hA5 ? 8'h00 : b);
            end
            len = int'($urandom_range(0, 10));
            pl.delete();
            s = len;
            for (int j = 0; j < len; j++) begin
                pl.push_back(8'($urandom));
                s += int'(pl[j]);
            end
            chk = ($urandom_range(0, 3) != 0) ? 8'(256 - (s % 256)) : 8'($urandom);
            exp_kind = model(len, pl, chk);
            if (exp_kind == 0) expect_payload(pl);
            send(8'hA5);
            send(8'(len));
            if (exp_kind != 2) begin
                foreach (pl[j]) begin
                    for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
                    send(pl[j]);
                end
                send(chk);
            end
            wait_drained("rand");
            tick(); tick();
            n_cmp++;
            if ({c_ok - ok0, c_chk - ck0, c_len - ln0} !==
                {int'(exp_kind == 0), int'(exp_kind == 1), int'(exp_kind == 2)}) begin
                n_err++;
                $display("FAIL rand_pkt%0d: got ok/chk/len %0d/%0d/%0d want kind %0d",
                         p, c_ok - ok0, c_chk - ck0, c_len - ln0, exp_kind);
            end
        end
        rand_ready = 1'b0;
        tick();
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_chk_err();
        test_len_err();
        test_timeout();
        test_framing();
        test_drop_and_async_reset();
        test_random();
        n_cmp++;
        if (expq.size() != 0) begin
            n_err++;
            $display("FAIL stream_leftover: got %0d bytes pending want 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
